// File: rtl/instr_encoder_if.sv
// Symbolic-instruction handshake bundle feeding the program loader.
// master drives fields and valid; slave returns ready.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_op, in_rs, in_rt,
    output in_rd, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt,
    input  in_rd, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instructions into MIPS words and streams them
// into instruction memory, one word every two cycles.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  instr_encoder_if.slave    bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_op
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              ready, hs, legal;
  logic [31:0]       enc;

  assign full       = count_q[ADDR_W];
  assign ready      = rst_n && (state_q == IDLE)
                      && !full && !clear;
  assign hs         = bus.in_valid && ready;
  assign bus.in_ready = ready;
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err_op     = err_q;

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    unique case (bus.in_op)
      4'd0: enc = {6'b000000, bus.in_rs, bus.in_rt,
                   bus.in_rd, 5'b0, 6'b100000};
      4'd1: enc = {6'b000000, bus.in_rs, bus.in_rt,
                   bus.in_rd, 5'b0, 6'b100010};
      4'd2: enc = {6'b000000, bus.in_rs, bus.in_rt,
                   bus.in_rd, 5'b0, 6'b100100};
      4'd3: enc = {6'b000000, bus.in_rs, bus.in_rt,
                   bus.in_rd, 5'b0, 6'b100101};
      4'd4: enc = {6'b000000, bus.in_rs, bus.in_rt,
                   bus.in_rd, 5'b0, 6'b101010};
      4'd5: enc = {6'b001101, bus.in_rs, bus.in_rt,
                   bus.in_imm};
      4'd6: enc = {6'b100011, bus.in_rs, bus.in_rt,
                   bus.in_imm};
      4'd7: enc = {6'b101011, bus.in_rs, bus.in_rt,
                   bus.in_imm};
      4'd8: enc = {6'b000100, bus.in_rs, bus.in_rt,
                   bus.in_imm};
      4'd9: enc = {6'b000010, bus.in_target};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
          err_d   = 1'b0;
        end else if (hs) begin
          if (legal) begin
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        // clear still lets the pending write land
        if (clear) begin
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, handshake,
// illegal ops, clear, reset and full on a narrow instance.
module tb_instr_encoder;

  logic clk;
  logic rst_n;
  logic clear;
  logic clear_s;

  instr_encoder_if bus ();
  instr_encoder_if bus_s ();

  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  cnt;
  logic        full;
  logic        err;

  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_cnt;
  logic        s_full;
  logic        s_err;

  instr_encoder #(.ADDR_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .imem_we    (we),
    .imem_addr  (addr),
    .imem_wdata (wdata),
    .count      (cnt),
    .full       (full),
    .err_op     (err)
  );

  instr_encoder #(.ADDR_W(2)) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_s),
    .bus        (bus_s),
    .imem_we    (s_we),
    .imem_addr  (s_addr),
    .imem_wdata (s_wdata),
    .count      (s_cnt),
    .full       (s_full),
    .err_op     (s_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [10];
  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_op     = v.op;
    bus.in_rs     = v.rs;
    bus.in_rt     = v.rt;
    bus.in_rd     = v.rd;
    bus.in_imm    = v.imm;
    bus.in_target = v.tgt;
  endtask

  task automatic junk();
    bus.in_op     = 4'd9;
    bus.in_rs     = 5'd17;
    bus.in_rt     = 5'd22;
    bus.in_rd     = 5'd9;
    bus.in_imm    = 16'hA5A5;
    bus.in_target = 26'h1555555;
  endtask

  // called at an IDLE negedge, returns at the next IDLE negedge
  task automatic send(input vec_t v, input int a);
    drive(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("send_we", 32'(we), 32'd1);
    chk("send_addr", 32'(addr), 32'(a));
    chk("send_data", wdata, v.exp);
    @(negedge clk);
  endtask

  initial begin
    vec_t bad;
    int   nwr;
    checks = 0;
    errors = 0;

    tv[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF,
              26'h3FFFFFF, 32'h00221820};
    tv[1] = '{4'd5, 5'd0,  5'd8,  5'd31, 16'h00FF,
              26'h3FFFFFF, 32'h340800FF};
    tv[2] = '{4'd6, 5'd29, 5'd9,  5'd31, 16'h0004,
              26'h3FFFFFF, 32'h8FA90004};
    tv[3] = '{4'd8, 5'd1,  5'd2,  5'd31, 16'hFFFF,
              26'h3FFFFFF, 32'h1022FFFF};
    tv[4] = '{4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF,
              26'h0000010, 32'h08000010};
    tv[5] = '{4'd1, 5'd4,  5'd5,  5'd6,  16'hFFFF,
              26'h3FFFFFF, 32'h00853022};
    tv[6] = '{4'd2, 5'd7,  5'd8,  5'd9,  16'hFFFF,
              26'h3FFFFFF, 32'h00E84824};
    tv[7] = '{4'd3, 5'd31, 5'd31, 5'd31, 16'hFFFF,
              26'h3FFFFFF, 32'h03FFF825};
    tv[8] = '{4'd4, 5'd10, 5'd11, 5'd12, 16'hFFFF,
              26'h3FFFFFF, 32'h014B602A};
    tv[9] = '{4'd7, 5'd2,  5'd3,  5'd31, 16'h8000,
              26'h3FFFFFF, 32'hAC438000};
    bad   = '{4'hF, 5'd1,  5'd2,  5'd3,  16'h1234,
              26'h0, 32'h0};

    rst_n = 1'b0;
    clear = 1'b0;
    clear_s = 1'b0;
    bus.in_valid = 1'b0;
    bus_s.in_valid = 1'b0;
    bus_s.in_op = 4'd0;
    bus_s.in_rs = 5'd1;
    bus_s.in_rt = 5'd2;
    bus_s.in_rd = 5'd3;
    bus_s.in_imm = 16'h0;
    bus_s.in_target = 26'h0;
    junk();

    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // table, in_valid held high; stale fields offered during WRITE
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(tv[i]);
      #1;
      chk("tbl_ready_idle", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk("tbl_we", 32'(we), 32'd1);
      chk("tbl_addr", 32'(addr), 32'(i));
      chk("tbl_data", wdata, tv[i].exp);
      chk("tbl_ready_wr", 32'(bus.in_ready), 32'd0);
      junk();
      @(negedge clk);
      chk("tbl_we_low", 32'(we), 32'd0);
      chk("tbl_addr_hold", 32'(addr), 32'(i));
      chk("tbl_data_hold", wdata, tv[i].exp);
      chk("tbl_count", 32'(cnt), 32'(i + 1));
    end
    bus.in_valid = 1'b0;

    // illegal mnemonic
    drive(bad);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ill_we", 32'(we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(cnt), 32'd10);
    @(negedge clk);
    chk("ill_we2", 32'(we), 32'd0);
    chk("ill_sticky", 32'(err), 32'd1);
    send(tv[0], 10);
    chk("ill_after_cnt", 32'(cnt), 32'd11);
    chk("ill_after_err", 32'(err), 32'd1);

    // clear while idle blocks the handshake
    clear = 1'b1;
    drive(tv[1]);
    bus.in_valid = 1'b1;
    #1;
    chk("clr_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_no_we", 32'(we), 32'd0);
    chk("clr_count", 32'(cnt), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    #1;
    chk("clr_ready_after", 32'(bus.in_ready), 32'd1);

    // clear during the write to addr 5
    for (int i = 0; i < 5; i++) send(tv[i], i);
    drive(bad);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("cw_err_set", 32'(err), 32'd1);
    drive(tv[5]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear = 1'b1;
    chk("cw_we", 32'(we), 32'd1);
    chk("cw_addr", 32'(addr), 32'd5);
    chk("cw_data", wdata, tv[5].exp);
    @(negedge clk);
    clear = 1'b0;
    chk("cw_we_low", 32'(we), 32'd0);
    chk("cw_count", 32'(cnt), 32'd0);
    chk("cw_err", 32'(err), 32'd0);

    // reset in the middle of the write to addr 2
    send(tv[6], 0);
    send(tv[7], 1);
    drive(tv[8]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rw_we", 32'(we), 32'd1);
    chk("rw_addr", 32'(addr), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_we_drop", 32'(we), 32'd0);
    chk("rw_count", 32'(cnt), 32'd0);
    chk("rw_ready", 32'(bus.in_ready), 32'd0);
    chk("rw_data", wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(tv[2], 0);
    chk("rw_after_cnt", 32'(cnt), 32'd1);

    // narrow instance fills up after four words
    bus_s.in_valid = 1'b1;
    nwr = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (s_we) begin
        chk("full_addr", 32'(s_addr), 32'(nwr));
        chk("full_data", s_wdata, 32'h00221820);
        nwr++;
      end
    end
    chk("full_nwr", 32'(nwr), 32'd4);
    chk("full_flag", 32'(s_full), 32'd1);
    chk("full_ready", 32'(bus_s.in_ready), 32'd0);
    chk("full_count", 32'(s_cnt), 32'd4);
    bus_s.in_valid = 1'b0;
    clear_s = 1'b1;
    @(negedge clk);
    clear_s = 1'b0;
    #1;
    chk("full_clr_cnt", 32'(s_cnt), 32'd0);
    chk("full_clr_flag", 32'(s_full), 32'd0);
    chk("full_clr_ready", 32'(bus_s.in_ready), 32'd1);
    chk("full_clr_err", 32'(s_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
